// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding request to instruction memory, holds the
// fetched word for decode until accepted, and handles redirects, wrap and ack timeout.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [6:0]  opcode,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   input  logic        instr_accept,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        misaligned,
   output logic        fetch_fault
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] fetch_pc;
   logic [7:0]  wait_cnt;
   logic        armed;
   logic        fetch_done;
   logic        fetch_timeout;
   logic        take;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   assign fetch_done    = imem_req && imem_ack;
   assign fetch_timeout = imem_req && !imem_ack && (wait_cnt == WAIT_LAST);
   assign take          = (state == HOLD) && instr_accept;

   always_comb begin
      state_nxt = state;
      unique case (state)
         FETCH: begin
            if (fetch_done) begin
               state_nxt = HOLD;
            end else if (fetch_timeout) begin
               state_nxt = FAULT;
            end
         end
         HOLD: begin
            if (instr_accept) begin
               state_nxt = FETCH;
            end
         end
         FAULT: state_nxt = FAULT;
         default: state_nxt = FETCH;
      endcase
   end

   // armed stays low through the first edge after reset release, so the request
   // cannot appear while reset is asserted or in the same cycle it deasserts.
   always_comb begin
      imem_req    = (state == FETCH) && armed;
      instr_valid = (state == HOLD);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         armed       <= 1'b0;
         fetch_pc    <= RESET_PC;
         instr       <= NOP;
         pc          <= RESET_PC;
         wait_cnt    <= '0;
         misaligned  <= 1'b0;
         fetch_fault <= 1'b0;
      end else begin
         armed <= 1'b1;
         if (fetch_done) begin
            instr    <= imem_rdata;
            pc       <= fetch_pc;
            wait_cnt <= '0;
         end else if (fetch_timeout) begin
            fetch_fault <= 1'b1;
         end else if (imem_req) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
         if (take) begin
            if (redirect) begin
               fetch_pc <= {redirect_target[31:2], 2'b00};
               if (redirect_target[1:0] != 2'b00) begin
                  misaligned <= 1'b1;
               end
            end else begin
               fetch_pc <= pc_plus4;
            end
         end
      end
   end

   assign imem_addr = fetch_pc;
   assign opcode    = instr[6:0];
   assign pc_plus4  = pc + 32'd4;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter TIMEOUT, default 255, is the maximum wait cycles for imem_ack before fault, range 1..255.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address, held stable while imem_req=1.
REQ-007 imem_ack  input  1  memory completion; imem_rdata valid in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr  output  32  latched instruction for the decode stage.
REQ-010 opcode  output  7  instr[6:0], feeds the main decoder.
REQ-011 pc  output  32  address from which instr was fetched.
REQ-012 pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-013 instr_valid  output  1  instr/pc hold a valid, unconsumed instruction.
REQ-014 instr_accept  input  1  downstream consumes instr this cycle.
REQ-015 redirect  input  1  taken branch/jump for the consumed instruction.
REQ-016 redirect_target  input  32  next fetch address when redirect=1.
REQ-017 misaligned  output  1  sticky flag: a redirect_target with nonzero bits [1:0] was seen.
REQ-018 fetch_fault  output  1  sticky flag: imem_ack timeout occurred.

Function
REQ-019 FSM has three states: FETCH, HOLD, FAULT.
REQ-020 FETCH: imem_req=1, imem_addr=fetch_pc, instr_valid=0; a wait counter increments each cycle without imem_ack.
REQ-021 FETCH with imem_ack=1: on the next edge, capture instr<=imem_rdata and pc<=fetch_pc, clear the wait counter, and enter HOLD (one-cycle latency).
REQ-022 FETCH, no ack, counter==TIMEOUT-1: on the next edge enter FAULT and set fetch_fault=1.
REQ-023 HOLD: imem_req=0, instr_valid=1; instr and pc are held unchanged until instr_accept=1.
REQ-024 HOLD with instr_accept=1 and redirect=0: fetch_pc<=pc+4, enter FETCH.
REQ-025 HOLD with instr_accept=1 and redirect=1: fetch_pc<={redirect_target[31:2],2'b00}, enter FETCH; set misaligned if redirect_target[1:0]!=0.
REQ-026 redirect is ignored when instr_accept=0 or the state is not HOLD.
REQ-027 instr_accept is ignored outside HOLD; no instruction is consumed twice or dropped.
REQ-028 FAULT: imem_req=0, instr_valid=0; the block leaves FAULT only by reset.
REQ-029 pc+4 wraps: 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
REQ-030 imem_ack while imem_req=0 is ignored.
REQ-031 At most one outstanding request; no new request before the prior one is acknowledged.

Reset
REQ-032 reset=0 asynchronously forces: state=FETCH, fetch_pc=RESET_PC, instr=32'h0000_0013 (NOP), pc=RESET_PC, instr_valid=0, misaligned=0, fetch_fault=0, wait counter=0.
REQ-033 While reset=0: imem_req=0; imem_req first asserts in the cycle after reset deasserts.
REQ-034 Reset asserted mid-FETCH or mid-HOLD aborts the request and discards the held instruction, with no residual state.

Verification
REQ-035 Sequential fetch: acks of 0x00500093 and 0x00A00113 with accept -> imem_addr 0x0, then 0x4; pc 0x0/0x4; opcode 7'b0010011 both times.
REQ-036 Backpressure: in HOLD, instr_accept=0 for 5 cycles -> instr_valid stays 1, imem_req stays 0, instr and pc unchanged.
REQ-037 Redirect: accept+redirect with target 0x100 -> next imem_addr=0x100. Target 0x102 -> imem_addr=0x100 and misaligned=1.
REQ-038 Wrap: fetch_pc=0xFFFFFFFC, acked and accepted -> pc_plus4=0x0 and next imem_addr=0x0.
REQ-039 Timeout: TIMEOUT=4 with no ack -> fetch_fault=1 after 4 cycles of imem_req; imem_req=0 thereafter until reset.
REQ-040 Async reset during HOLD, between clock edges -> instr_valid=0 and pc=RESET_PC immediately; after release, first imem_addr=RESET_PC.
